// File: rtl/i2c_master_tx.sv
// Write-only I2C bus master: START, {ADDRESS,0}, NUM_BYTES payload bytes MSB-first, STOP.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching on released-SCL quarters.
module i2c_master_tx #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned NUM_BYTES = 32,
  parameter logic [6:0]  ADDRESS   = 7'h6A
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [8*NUM_BYTES-1:0] data_in,
  output logic                   busy,
  output logic                   done,
  output logic                   nack,
  output logic [7:0]             byte_idx,
  inout  wire                    scl,
  inout  wire                    sda
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BufW = 8 * NUM_BYTES;

  typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      tx_q, tx_d;
  logic [BufW-1:0] payload_q, payload_d;
  logic            nack_q, nack_d;
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic            scl_low, sda_low;
  logic            stall, wrap;

`ifdef I2C_CLK_STRETCH_EN
  logic [1:0] scl_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) scl_sync_q <= 2'b11;
    else       scl_sync_q <= {scl_sync_q[0], scl};
  end

  // Hold the quarter at its first cycle while a slave keeps a released SCL low.
  assign stall = (state_q != StIdle) && !scl_low && (cnt_q == '0) && !scl_sync_q[1];
`else
  assign stall = 1'b0;
`endif

  assign wrap = (cnt_q == CntW'(CLK_DIV - 1)) && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      tx_q      <= '0;
      payload_q <= '0;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      payload_q <= payload_d;
      nack_q    <= nack_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    payload_d = payload_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    ack_d     = ack_q;

    if (state_q == StIdle || wrap) cnt_d = '0;
    else if (stall)                cnt_d = cnt_q;
    else                           cnt_d = cnt_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d   = StStart;
          qtr_d     = '0;
          bit_d     = '0;
          idx_d     = '0;
          tx_d      = {ADDRESS, 1'b0};
          payload_d = data_in;
          nack_d    = 1'b0;
        end
      end
      StStart: begin
        if (wrap) begin
          qtr_d = qtr_q + 1'b1;
          if (qtr_q == 2'd1) begin
            state_d = StBit;
            qtr_d   = '0;
          end
        end
      end
      StBit: begin
        if (wrap) begin
          qtr_d = qtr_q + 1'b1;
          if (qtr_q == 2'd3) begin
            tx_d  = {tx_q[6:0], 1'b0};
            bit_d = bit_q + 1'b1;
            if (bit_q == 3'd7) state_d = StAck;
          end
        end
      end
      StAck: begin
        if (qtr_q == 2'd3 && cnt_q == '0) ack_d = sda;
        if (wrap) begin
          qtr_d = qtr_q + 1'b1;
          if (qtr_q == 2'd3) begin
            qtr_d = '0;
            if (ack_q) begin
              nack_d  = 1'b1;
              state_d = StStop;
            end else if (idx_q == 8'(NUM_BYTES)) begin
              state_d = StStop;
            end else begin
              idx_d     = idx_q + 1'b1;
              tx_d      = payload_q[BufW-1 -: 8];
              payload_d = payload_q << 8;
              bit_d     = '0;
              state_d   = StBit;
            end
          end
        end
      end
      StStop: begin
        if (wrap) begin
          qtr_d = qtr_q + 1'b1;
          if (qtr_q == 2'd2) begin
            qtr_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line drive decoded straight from registered state so reset releases both lines at once.
  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StStart: sda_low = (qtr_q == 2'd1);
      StBit: begin
        scl_low = (qtr_q < 2'd2);
        sda_low = !tx_q[7];
      end
      StAck:   scl_low = (qtr_q < 2'd2);
      StStop: begin
        scl_low = (qtr_q == 2'd0);
        sda_low = (qtr_q != 2'd2);
      end
      default: ;
    endcase
  end

  assign scl      = scl_low ? 1'b0 : 1'bz;
  assign sda      = sda_low ? 1'b0 : 1'bz;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign nack     = nack_q;
  assign byte_idx = idx_q;

endmodule
